// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
//   Iterative signed multiplier / divider placed after the register file.
//   One operation in flight; the result is written back when data_resultRDY
//   pulses, a fixed WIDTH+1 rising edges after the start edge.
//
// Ports
//   clock          in   system clock, rising edge
//   ctrl_reset     in   synchronous reset, active low
//   ctrl_MULT      in   start a signed multiply (ignored if ctrl_DIV also high)
//   ctrl_DIV       in   start a signed divide   (ignored if ctrl_MULT also high)
//   data_operandA  in   multiplicand / dividend
//   data_operandB  in   multiplier   / divisor
//   data_result    out  low WIDTH bits of product, or quotient
//   data_exception out  multiply overflow, divide-by-zero or MIN/-1 overflow
//   data_resultRDY out  one-cycle pulse, result and exception valid
//   busy           out  operation in flight (start edge through RDY cycle)
// ---------------------------------------------------------------------------
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int LATENCY = WIDTH + 1;
    localparam int CW      = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Shared datapath: r_hi/r_lo form the partial product (multiply) or the
    // partial remainder / quotient pair (divide); r_dvs holds the magnitude
    // of the multiplicand or of the divisor.
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_div0;
    logic             r_divovf;

    logic             w_start;
    logic             w_active;
    logic             w_last;
    logic             w_step;
    logic             w_finish;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;

    logic [WIDTH+1:0] w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_q_bit;

    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_quo;

    logic [WIDTH-1:0] w_res_next;
    logic             w_exc_next;
    logic             w_rdy_next;
    logic             w_busy_next;

    assign w_start  = ctrl_MULT ^ ctrl_DIV;
    assign w_active = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_last   = (r_cnt == CW'(LATENCY - 1));

    // Operand magnitudes in WIDTH+1 bits so the most negative value survives.
    assign w_a_ext = {data_operandA[WIDTH-1], data_operandA};
    assign w_b_ext = {data_operandB[WIDTH-1], data_operandB};
    assign w_a_mag = w_a_ext[WIDTH] ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_ext[WIDTH] ? -w_b_ext : w_b_ext;

    // Unsigned shift-add step: multiplier bits are consumed from r_lo[0].
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : '0);

    // Restoring divide step: dividend bits enter from r_lo MSB, quotient
    // bits shift into r_lo LSB.
    assign w_rem_sh   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_div_diff = {1'b0, w_rem_sh} - {1'b0, r_dvs};
    assign w_q_bit    = ~w_div_diff[WIDTH+1];

    // Signs are applied only once the magnitude operation is complete.
    assign w_prod_mag = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
    assign w_mul_ovf  = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quo      = r_neg ? -r_lo : r_lo;

    // State register
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a valid start overrides everything, including an
    // operation already in flight.
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ctrl_MULT ? S_MUL : S_DIV;
        end else begin
            case (r_state)
                S_IDLE:       w_state_next = S_IDLE;
                S_MUL, S_DIV: w_state_next = w_last ? S_DONE : r_state;
                S_DONE:       w_state_next = S_IDLE;
                default:      w_state_next = S_IDLE;
            endcase
        end
    end

    // Output / control logic feeding the registered outputs.
    always_comb begin
        w_step      = w_active && !w_last && !w_start;
        w_finish    = w_active &&  w_last && !w_start;
        w_rdy_next  = (w_state_next == S_DONE);
        w_busy_next = (w_state_next != S_IDLE);
        w_res_next  = data_result;
        w_exc_next  = data_exception;
        if (w_finish) begin
            if (r_state == S_MUL) begin
                w_res_next = w_prod[WIDTH-1:0];
                w_exc_next = w_mul_ovf;
            end else if (r_div0) begin
                w_res_next = '0;
                w_exc_next = 1'b1;
            end else begin
                w_res_next = w_quo;
                w_exc_next = r_divovf;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_result    <= w_res_next;
            data_exception <= w_exc_next;
            data_resultRDY <= w_rdy_next;
            busy           <= w_busy_next;
        end
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_divovf <= 1'b0;
        end else if (w_start) begin
            r_hi     <= '0;
            r_cnt    <= '0;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_div0   <= (data_operandB == '0);
            r_divovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
            if (ctrl_MULT) begin
                r_dvs <= w_a_mag;
                r_lo  <= w_b_mag[WIDTH-1:0];
            end else begin
                r_dvs <= w_b_mag;
                r_lo  <= w_a_mag[WIDTH-1:0];
            end
        end else if (w_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_state == S_MUL) begin
                r_hi <= w_mul_sum[WIDTH+1:1];
                r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= w_q_bit ? w_div_diff[WIDTH:0] : w_rem_sh;
                r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// ---------------------------------------------------------------------------
// tb_multdiv_unit
//   Scoreboard bench for multdiv_unit. Stimulus pushes the expected result,
//   exception and RDY edge number; a monitor pops on every RDY pulse.
// ---------------------------------------------------------------------------
module tb_multdiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clock = 1'b0;
    logic         ctrl_reset;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           at;
    } exp_t;

    exp_t sb[$];

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // edge_n equals the index of the most recent rising edge.
    always @(posedge clock) edge_n <= edge_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: plain signed arithmetic on the architectural values.
    task automatic model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic e);
        longint p;
        longint lim;
        int     q;
        lim = 64'sh7FFF_FFFF;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[W-1:0];
            e = (p > lim) || (p < -lim - 1);
        end else if (b == 0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endtask

    // Monitor: every RDY pulse must match the oldest expected entry.
    always @(posedge clock) begin
        #1;
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdy: got RDY=1 expected no RDY (edge %0d, result %h)",
                         edge_n, data_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdy_edge", W'(edge_n), W'(e.at));
                check("result", data_result, e.res);
                check("exception", W'(data_exception), W'(e.exc));
            end
        end
    end

    // Drive a start for one edge; s returns the start edge index.
    task automatic start_raw(input bit mult, input bit div, input logic [W-1:0] a,
                             input logic [W-1:0] b, output int s);
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        s             = edge_n;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic push_exp(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int s, output logic [W-1:0] r, output logic e);
        exp_t x;
        model(is_div, a, b, r, e);
        x.res = r;
        x.exc = e;
        x.at  = s + LAT;
        sb.push_back(x);
    endtask

    // Follow an operation started at edge s through RDY and the hold period.
    task automatic wait_done(input int s, input logic [W-1:0] r, input logic e);
        while (edge_n < s + LAT - 1) begin
            @(posedge clock);
            #1;
        end
        check("busy_before_rdy", W'(busy), 1);
        check("rdy_early", W'(data_resultRDY), 0);
        @(posedge clock);
        #1;
        check("busy_at_rdy", W'(busy), 1);
        @(posedge clock);
        #1;
        check("busy_after_rdy", W'(busy), 0);
        check("rdy_width", W'(data_resultRDY), 0);
        check("result_after", data_result, r);
        check("exc_after", W'(data_exception), W'(e));
        repeat (3) @(posedge clock);
        #1;
        check("result_hold", data_result, r);
        check("exc_hold", W'(data_exception), W'(e));
    endtask

    task automatic run_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        int           s;
        logic [W-1:0] r;
        logic         e;
        start_raw(!is_div, is_div, a, b, s);
        push_exp(is_div, a, b, s, r, e);
        check("busy_start", W'(busy), 1);
        wait_done(s, r, e);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom_range(0, 255));
            6:       return -W'($urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int           s0;
        int           s1;
        logic [W-1:0] r;
        logic         e;

        ctrl_reset    = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        check("reset_result", data_result, 0);
        check("reset_exc", W'(data_exception), 0);
        check("reset_rdy", W'(data_resultRDY), 0);
        check("reset_busy", W'(busy), 0);
        repeat (40) @(posedge clock);
        #1;
        check("idle_busy", W'(busy), 0);

        // Directed multiply cases
        run_op(1'b0, 32'd7, 32'hFFFF_FFFA);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op(1'b0, 32'h8000_0000, 32'd1);
        run_op(1'b0, 32'd0, 32'h1234_5678);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Directed divide cases
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(1'b1, 32'd100, 32'd0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 32'h8000_0000, 32'd1);
        run_op(1'b1, 32'd5, 32'h8000_0000);
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);

        // Restart while busy: the multiply never reports
        start_raw(1'b1, 1'b0, 32'd3, 32'd5, s0);
        repeat (9) @(posedge clock);
        #1;
        start_raw(1'b0, 1'b1, 32'd100, 32'd7, s1);
        check("restart_edge", W'(s1 - s0), 10);
        push_exp(1'b1, 32'd100, 32'd7, s1, r, e);
        check("restart_model", r, 14);
        wait_done(s1, r, e);

        // Both starts high in IDLE: ignored
        start_raw(1'b1, 1'b1, 32'd9, 32'd9, s0);
        check("both_idle_busy", W'(busy), 0);
        repeat (40) @(posedge clock);
        #1;
        check("both_idle_busy_late", W'(busy), 0);

        // Both starts high while busy: current operation continues
        start_raw(1'b1, 1'b0, 32'd9, 32'hFFFF_FFF5, s0);
        push_exp(1'b0, 32'd9, 32'hFFFF_FFF5, s0, r, e);
        repeat (4) @(posedge clock);
        #1;
        start_raw(1'b1, 1'b1, 32'd1, 32'd1, s1);
        wait_done(s0, r, e);

        // Reset in the middle of a multiply
        start_raw(1'b1, 1'b0, 32'd1234, 32'd5678, s0);
        repeat (19) @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        check("midreset_edge", W'(edge_n - s0), 20);
        check("midreset_busy", W'(busy), 0);
        check("midreset_result", data_result, 0);
        check("midreset_exc", W'(data_exception), 0);
        check("midreset_rdy", W'(data_resultRDY), 0);
        repeat (40) @(posedge clock);
        #1;
        run_op(1'b0, 32'd2, 32'd3);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick());
        end

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_empty", W'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
